// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: move codes, scan codes,
// receiver state encoding and the scan-code-to-move lookup.
package ps2_pkg;

  localparam logic [2:0] KEY_NONE  = 3'b000;
  localparam logic [2:0] KEY_UP    = 3'b001;
  localparam logic [2:0] KEY_DOWN  = 3'b010;
  localparam logic [2:0] KEY_LEFT  = 3'b011;
  localparam logic [2:0] KEY_RIGHT = 3'b100;
  localparam logic [2:0] KEY_DIG   = 3'b101;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_75 = 8'h75;
  localparam logic [7:0] SC_72 = 8'h72;
  localparam logic [7:0] SC_6B = 8'h6B;
  localparam logic [7:0] SC_74 = 8'h74;
  localparam logic [7:0] SC_1D = 8'h1D;
  localparam logic [7:0] SC_1B = 8'h1B;
  localparam logic [7:0] SC_1C = 8'h1C;
  localparam logic [7:0] SC_23 = 8'h23;
  localparam logic [7:0] SC_29 = 8'h29;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // Arrow keys only count with the E0 prefix, WASD/space only without it.
  function automatic logic [2:0] map_make(input logic ext, input logic [7:0] code);
    logic [2:0] mv;
    mv = KEY_NONE;
    if (ext) begin
      case (code)
        SC_75:   mv = KEY_UP;
        SC_72:   mv = KEY_DOWN;
        SC_6B:   mv = KEY_LEFT;
        SC_74:   mv = KEY_RIGHT;
        default: mv = KEY_NONE;
      endcase
    end else begin
      case (code)
        SC_1D:   mv = KEY_UP;
        SC_1B:   mv = KEY_DOWN;
        SC_1C:   mv = KEY_LEFT;
        SC_23:   mv = KEY_RIGHT;
        SC_29:   mv = KEY_DIG;
        default: mv = KEY_NONE;
      endcase
    end
    return mv;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, ps2_clk glitch filter,
// start/data/parity/stop framing and an inactivity timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] scan_code_o,
  output logic       scan_valid_o,
  output logic       frame_err_o,
  output logic       timeout_o
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          fall_d;
  logic          bit_d;

  rx_state_e     state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    scan_code_q;
  logic          scan_valid_q;
  logic          frame_err_q;
  logic          timeout_q;

  // Two-flop synchronisers; lines idle high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
    end
  end

  // Filtered clock follows the synchronised clock only after FILTER_LEN equal samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (clk_sync_q[1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
      filt_q <= clk_sync_q[1];
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  // Falling edge is flagged in the cycle the filter accepts the new low level.
  always_comb begin
    fall_d = filt_q & ~clk_sync_q[1] & (fcnt_q == FW'(FILTER_LEN - 1));
    bit_d  = dat_sync_q[1];
  end

  // Frame FSM with timeout; an edge in the terminal-count cycle takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RX_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
      if (state_q == RX_IDLE) begin
        tmo_q <= '0;
        if (fall_d && !bit_d) begin
          state_q  <= RX_DATA;
          bitcnt_q <= '0;
        end
      end else if (fall_d) begin
        tmo_q <= '0;
        case (state_q)
          RX_DATA: begin
            shift_q  <= {bit_d, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            par_q   <= bit_d;
            state_q <= RX_STOP;
          end
          RX_STOP: begin
            if (bit_d && (^{shift_q, par_q})) begin
              scan_code_q  <= shift_q;
              scan_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        tmo_q       <= '0;
        frame_err_q <= 1'b1;
        timeout_q   <= 1'b1;
        state_q     <= RX_IDLE;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign scan_code_o  = scan_code_q;
  assign scan_valid_o = scan_valid_q;
  assign frame_err_o  = frame_err_q;
  assign timeout_o    = timeout_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to digger move decoder: receives frames via ps2_rx and turns
// make/break/extended sequences into a held 3-bit move code.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       sys_clk,
  input  logic       rst_key_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] key,
  output logic       key_pressed,
  output logic       key_strobe,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic       rx_timeout;
  logic       ext_q;
  logic       brk_q;
  logic [2:0] key_q;
  logic       key_pressed_q;
  logic       key_strobe_q;
  logic [2:0] code_d;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_i       (sys_clk),
    .rst_ni      (rst_key_n),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .scan_code_o (scan_code),
    .scan_valid_o(scan_valid),
    .frame_err_o (frame_err),
    .timeout_o   (rx_timeout)
  );

  // Move code of the current byte under the pending E0 prefix.
  always_comb begin
    code_d = map_make(ext_q, scan_code);
  end

  // Prefix flags and held-key registers, updated one cycle after scan_valid.
  always_ff @(posedge sys_clk or negedge rst_key_n) begin
    if (!rst_key_n) begin
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      key_q         <= KEY_NONE;
      key_pressed_q <= 1'b0;
      key_strobe_q  <= 1'b0;
    end else begin
      key_strobe_q <= 1'b0;
      if (rx_timeout) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (scan_valid) begin
        if (scan_code == SC_E0) begin
          ext_q <= 1'b1;
        end else if (scan_code == SC_F0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (code_d != KEY_NONE) begin
            if (brk_q) begin
              if (key_pressed_q && (code_d == key_q)) begin
                key_q         <= KEY_NONE;
                key_pressed_q <= 1'b0;
              end
            end else if (!key_pressed_q || (code_d != key_q)) begin
              key_q         <= code_d;
              key_pressed_q <= 1'b1;
              key_strobe_q  <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign key         = key_q;
  assign key_pressed = key_pressed_q;
  assign key_strobe  = key_strobe_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised scoreboard bench for ps2_key_decoder with a behavioural keyboard model.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int FL  = 8;
  localparam int TO  = 300;
  localparam int H   = 30;   // ps2_clk half period in sys_clk cycles

  logic       sys_clk = 1'b0;
  logic       rst_key_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [2:0] key;
  logic       key_pressed;
  logic       key_strobe;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  always #20 sys_clk = ~sys_clk;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .sys_clk    (sys_clk),
    .rst_key_n  (rst_key_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key        (key),
    .key_pressed(key_pressed),
    .key_strobe (key_strobe),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  typedef struct {
    bit       is_err;
    bit [7:0] code;
  } rx_ev_t;

  rx_ev_t   rxq[$];
  bit [2:0] strq[$];
  int       errors = 0;
  int       checks = 0;

  // Keyboard model state
  bit [2:0] make_map[bit [8:0]];
  bit       m_ext, m_brk, m_pressed;
  bit [2:0] m_key;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
  endtask

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_pressed = 0; m_key = 0;
  endfunction

  function automatic void model_byte(input bit [7:0] b);
    bit [2:0] mv;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      mv = make_map.exists({m_ext, b}) ? make_map[{m_ext, b}] : 3'd0;
      if (mv != 0) begin
        if (m_brk) begin
          if (m_pressed && mv == m_key) begin m_pressed = 0; m_key = 0; end
        end else if (!m_pressed || mv != m_key) begin
          m_key = mv; m_pressed = 1; strq.push_back(mv);
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // Drive the first n bits of an 11-bit frame (bit 0 = start), optionally with glitches.
  task automatic drive_bits(input bit [10:0] bits, input int n, input bit glitchy);
    int g;
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glitchy && $urandom_range(0, 1) == 1) begin
        g = $urandom_range(1, FL - 3);
        wait_cyc(3); ps2_clk = 0; wait_cyc(g); ps2_clk = 1; wait_cyc(H/2 - 3 - g);
      end else begin
        wait_cyc(H/2);
      end
      ps2_clk = 0;
      if (glitchy && $urandom_range(0, 1) == 1) begin
        g = $urandom_range(1, FL - 3);
        wait_cyc(12); ps2_clk = 1; wait_cyc(g); ps2_clk = 0; wait_cyc(H - 12 - g);
      end else begin
        wait_cyc(H);
      end
      ps2_clk = 1;
      wait_cyc(H/2);
    end
    ps2_data = 1;
  endtask

  function automatic bit [10:0] mk_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop);
    bit p;
    p = ~(^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic check_held(input string tag);
    check({tag, "_key"}, key, m_key);
    check({tag, "_pressed"}, key_pressed, m_pressed);
  endtask

  task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop, input bit glitchy);
    rx_ev_t ev;
    ev.is_err = bad_par | bad_stop;
    ev.code   = b;
    rxq.push_back(ev);
    if (!ev.is_err) model_byte(b);
    drive_bits(mk_frame(b, bad_par, bad_stop), 11, glitchy);
    wait_cyc(60);
    check_held("frame");
  endtask

  task automatic send_aborted(input bit [7:0] b, input int nbits);
    rx_ev_t ev;
    ev.is_err = 1;
    ev.code   = 0;
    rxq.push_back(ev);
    m_ext = 0; m_brk = 0;
    drive_bits(mk_frame(b, 0, 0), nbits, 0);
    wait_cyc(TO + 60);
    check_held("timeout");
  endtask

  task automatic check_reset_outputs();
    check("rst_key", key, 0);
    check("rst_pressed", key_pressed, 0);
    check("rst_strobe", key_strobe, 0);
    check("rst_scan_code", scan_code, 0);
    check("rst_scan_valid", scan_valid, 0);
    check("rst_frame_err", frame_err, 0);
  endtask

  // Monitor: every receiver event and strobe must match the next expected entry.
  initial begin
    rx_ev_t ev;
    bit [2:0] sk;
    forever begin
      @(negedge sys_clk);
      if (rst_key_n === 1'b1) begin
        if (scan_valid || frame_err) begin
          checks++;
          if (rxq.size() == 0) begin
            errors++;
            $display("FAIL rx_event: got valid=%0b err=%0b code=%02h, expected no event", scan_valid, frame_err, scan_code);
          end else begin
            ev = rxq.pop_front();
            if (frame_err !== ev.is_err || scan_valid !== !ev.is_err || (!ev.is_err && scan_code !== ev.code)) begin
              errors++;
              $display("FAIL rx_event: got valid=%0b err=%0b code=%02h, expected err=%0b code=%02h",
                       scan_valid, frame_err, scan_code, ev.is_err, ev.code);
            end
          end
        end
        if (key_strobe) begin
          checks++;
          if (strq.size() == 0) begin
            errors++;
            $display("FAIL key_strobe: got strobe with key=%0d, expected no strobe", key);
          end else begin
            sk = strq.pop_front();
            if (key !== sk || key_pressed !== 1'b1) begin
              errors++;
              $display("FAIL key_strobe: got key=%0d pressed=%0b, expected key=%0d pressed=1", key, key_pressed, sk);
            end
          end
        end
      end
    end
  end

  bit [7:0] pool[11] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29};

  initial begin
    bit [7:0] b;
    int r;
    make_map[{1'b1, 8'h75}] = 3'd1; make_map[{1'b0, 8'h1D}] = 3'd1;
    make_map[{1'b1, 8'h72}] = 3'd2; make_map[{1'b0, 8'h1B}] = 3'd2;
    make_map[{1'b1, 8'h6B}] = 3'd3; make_map[{1'b0, 8'h1C}] = 3'd3;
    make_map[{1'b1, 8'h74}] = 3'd4; make_map[{1'b0, 8'h23}] = 3'd4;
    make_map[{1'b0, 8'h29}] = 3'd5;
    model_reset();

    ps2_clk = 1; ps2_data = 1; rst_key_n = 0;
    wait_cyc(5);
    @(negedge sys_clk);
    check_reset_outputs();
    rst_key_n = 1;
    wait_cyc(20);

    // W make, then release
    send_frame(8'h1D, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0); send_frame(8'h1D, 0, 0, 0);
    // Extended up with typematic repeat, then extended break
    send_frame(8'hE0, 0, 0, 0); send_frame(8'h75, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0); send_frame(8'h75, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0); send_frame(8'hF0, 0, 0, 0); send_frame(8'h75, 0, 0, 0);
    // Overlapping A then D; break of A must not release D
    send_frame(8'h1C, 0, 0, 0); send_frame(8'h23, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0); send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0); send_frame(8'h23, 0, 0, 0);
    // Bad parity and bad stop
    send_frame(8'h29, 1, 0, 0);
    send_frame(8'h29, 0, 1, 0);
    // Timeout after five data bits, then a good space
    send_aborted(8'h29, 6);
    send_frame(8'h29, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0); send_frame(8'h29, 0, 0, 0);
    // Pending prefix is dropped by a timeout
    send_frame(8'hE0, 0, 0, 0);
    send_aborted(8'h11, 3);
    send_frame(8'h75, 0, 0, 0);
    // Glitchy clock on good frames
    send_frame(8'h1B, 0, 0, 1);
    send_frame(8'hF0, 0, 0, 1); send_frame(8'h1B, 0, 0, 1);

    // Reset during bit 4 of a frame, then a good S
    send_frame(8'h23, 0, 0, 0);
    drive_bits(mk_frame(8'h6B, 0, 0), 5, 0);
    ps2_data = 0;
    wait_cyc(H/2);
    ps2_clk = 0;
    wait_cyc(H/2);
    rst_key_n = 0;
    model_reset();
    rxq.delete();
    strq.delete();
    wait_cyc(3);
    @(negedge sys_clk);
    check_reset_outputs();
    ps2_clk = 1; ps2_data = 1;
    wait_cyc(5);
    rst_key_n = 1;
    wait_cyc(40);
    send_frame(8'h1B, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 15);
      if (r < 11) b = pool[r];
      else b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 11) == 0) begin
        send_aborted(b, $urandom_range(1, 10));
      end else begin
        r = $urandom_range(0, 9);
        send_frame(b, r == 0, r == 1, $urandom_range(0, 3) == 0);
      end
    end

    wait_cyc(100);
    check("rx_queue_drained", rxq.size(), 0);
    check("strobe_queue_drained", strq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
